// File: rtl/encoder_pkg.sv
// Shared encoder controller types: FSM state, stage index names and default sizes.
package encoder_pkg;
  localparam int NUM_STAGES_DEF = 5;
  localparam int ROUND_W_DEF    = 5;

  localparam int STG_PAR = 0;
  localparam int STG_ROT = 1;
  localparam int STG_PER = 2;
  localparam int STG_REV = 3;
  localparam int STG_RC  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_e;
endpackage

// File: rtl/encoder_stage_pick.sv
// Priority search for the next enabled stage above cur_i; wraps to the lowest
// enabled stage when none remain higher.
module encoder_stage_pick
  import encoder_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  localparam int IDXW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic [NUM_STAGES-1:0] mask_i,
  input  logic [IDXW-1:0]       cur_i,
  output logic [IDXW-1:0]       nxt_o,
  output logic                  wrap_o,
  output logic                  none_o
);
  logic [IDXW-1:0] lo, hi;
  logic            found;

  always_comb begin
    lo    = '0;
    hi    = '0;
    found = 1'b0;
    // Descending scan: the last hit is the lowest match.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lo = IDXW'(i);
        if (i > int'(cur_i)) begin
          hi    = IDXW'(i);
          found = 1'b1;
        end
      end
    end
    wrap_o = !found;
    nxt_o  = found ? hi : lo;
    none_o = ~|mask_i;
  end
endmodule

// File: rtl/encoder_round_ctrl.sv
// Round sequencer: READ, then rounds of masked stage launches, then WRITE.
// Define STAGE_TIMEOUT_EN to add the per-stage watchdog and ERR state.
module encoder_round_ctrl
  import encoder_pkg::*;
#(
  parameter int NUM_STAGES     = NUM_STAGES_DEF,
  parameter int ROUND_W        = ROUND_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDXW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROUND_W-1:0]    num_rounds,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic [NUM_STAGES-1:0] ready_stage,
  output logic                  ready,
  output logic                  busy,
  output logic                  ld_fr,
  output logic                  ld_fw,
  output logic [NUM_STAGES-1:0] start_stage,
  output logic [IDXW-1:0]       stage_idx,
  output logic [ROUND_W-1:0]    round_idx,
  output logic                  err
);
  state_e                state_q, state_d;
  logic [IDXW-1:0]       stage_q, stage_d, pick_cur, pick_nxt;
  logic [ROUND_W-1:0]    round_q, round_d, nrounds_q, nrounds_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic                  pick_wrap, pick_none, rdy_cur, last_round;

`ifdef STAGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  // In READ, searching above the top index yields the lowest enabled stage.
  assign pick_cur   = (state_q == ST_READ) ? IDXW'(NUM_STAGES - 1) : stage_q;
  assign rdy_cur    = ready_stage[stage_q];
  assign last_round = (round_q == nrounds_q - ROUND_W'(1));

  encoder_stage_pick #(.NUM_STAGES(NUM_STAGES)) u_pick (
    .mask_i (mask_q),
    .cur_i  (pick_cur),
    .nxt_o  (pick_nxt),
    .wrap_o (pick_wrap),
    .none_o (pick_none)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    round_d   = round_q;
    nrounds_d = nrounds_q;
    mask_d    = mask_q;
    case (state_q)
      ST_IDLE: if (start) begin
        nrounds_d = num_rounds;
        mask_d    = stage_mask;
        state_d   = ST_READ;
      end
      ST_READ: begin
        if (nrounds_q == '0 || pick_none) begin
          state_d = ST_WRITE;
        end else begin
          stage_d = pick_nxt;
          round_d = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: if (!rdy_cur) state_d = ST_WAIT;
      ST_WAIT: if (rdy_cur) begin
        stage_d = pick_nxt;
        if (pick_wrap && last_round) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_LAUNCH;
          if (pick_wrap) round_d = round_q + ROUND_W'(1);
        end
      end
      ST_WRITE: begin
        stage_d = '0;
        round_d = '0;
        state_d = ST_IDLE;
      end
`ifdef STAGE_TIMEOUT_EN
      ST_ERR: if (start) begin
        stage_d = '0;
        round_d = '0;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef STAGE_TIMEOUT_EN
    wdog_d = wdog_q;
    if (state_q == ST_LAUNCH || state_q == ST_WAIT) begin
      if (state_q == ST_WAIT && rdy_cur) begin
        wdog_d = '0;
      end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        // Fault keeps stage/round pointing at the stuck unit.
        state_d = ST_ERR;
        stage_d = stage_q;
        round_d = round_q;
        wdog_d  = '0;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end else begin
      wdog_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      round_q   <= '0;
      nrounds_q <= '0;
      mask_q    <= '0;
`ifdef STAGE_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      round_q   <= round_d;
      nrounds_q <= nrounds_d;
      mask_q    <= mask_d;
`ifdef STAGE_TIMEOUT_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_READ) || (state_q == ST_LAUNCH) ||
                       (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign ld_fr       = (state_q == ST_READ);
  assign ld_fw       = (state_q == ST_WRITE);
  assign start_stage = (state_q == ST_LAUNCH && rdy_cur) ?
                       (NUM_STAGES'(1) << stage_q) : '0;
  assign stage_idx   = stage_q;
  assign round_idx   = round_q;
`ifdef STAGE_TIMEOUT_EN
  assign err         = (state_q == ST_ERR);
`else
  assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_encoder_round_ctrl.sv
// Bench for encoder_round_ctrl: behavioural stage units, a launch-list model
// checked every cycle, and hand-computed run lengths pinning the model.
module tb_encoder_round_ctrl;
  localparam int NS = 5;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] num_rounds = '0;
  logic [NS-1:0] stage_mask = '0;
  logic [NS-1:0] ready_stage;
  logic          ready, busy, ld_fr, ld_fw, err;
  logic [NS-1:0] start_stage;
  logic [2:0]    stage_idx;
  logic [RW-1:0] round_idx;

  always #5 clk = ~clk;

  encoder_round_ctrl #(.NUM_STAGES(NS), .ROUND_W(RW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rounds(num_rounds),
    .stage_mask(stage_mask), .ready_stage(ready_stage), .ready(ready),
    .busy(busy), .ld_fr(ld_fr), .ld_fw(ld_fw), .start_stage(start_stage),
    .stage_idx(stage_idx), .round_idx(round_idx), .err(err)
  );

  // Stage unit behaviour: ack after ack_after start cycles, busy low_len cycles.
  int ack_after[NS];
  int low_len[NS];
  int hi_cnt[NS];
  int lo_cnt[NS];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_stage <= '1;
      for (int i = 0; i < NS; i++) begin
        hi_cnt[i] <= 0;
        lo_cnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (ready_stage[i] && start_stage[i]) begin
          if (hi_cnt[i] + 1 >= ack_after[i]) begin
            ready_stage[i] <= 1'b0;
            lo_cnt[i]      <= low_len[i];
            hi_cnt[i]      <= 0;
          end else begin
            hi_cnt[i] <= hi_cnt[i] + 1;
          end
        end else if (!ready_stage[i]) begin
          if (lo_cnt[i] <= 1) ready_stage[i] <= 1'b1;
          lo_cnt[i] <= lo_cnt[i] - 1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int lit_fw, lit_launch, lit_hold2, lit_err_cyc;
  int done_cnt = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Model: on accept, expand rounds x enabled stages into an ordered launch list
  // and derive the run length from the stage units' known timing.
  int            q_s[$];
  int            q_r[$];
  bit            m_act = 1'b0;
  bit            err_ph = 1'b0;
  int            cyc, exp_len, cur_s, cur_r, hold, hold2, n_launch, fw_cyc;
  logic [NS-1:0] prev_ss = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_start_stage", start_stage, 0);
      chk("rst_stage_idx", stage_idx, 0);
      chk("rst_round_idx", round_idx, 0);
      chk("rst_ld_fr", ld_fr, 0);
      chk("rst_ld_fw", ld_fw, 0);
      chk("rst_err", err, 0);
      m_act = 1'b0;
      err_ph = 1'b0;
      q_s.delete();
      q_r.delete();
      hold = 0;
      prev_ss = '0;
    end else if (m_act) begin
      cyc++;
      if (lit_err_cyc > 0 && cyc == lit_err_cyc) begin
        chk("err_flag", err, 1);
        chk("err_ready", ready, 0);
        chk("err_busy", busy, 0);
        chk("err_start_stage", start_stage, 0);
        chk("err_stage_idx", stage_idx, cur_s);
        chk("err_round_idx", round_idx, cur_r);
        m_act = 1'b0;
        err_ph = 1'b1;
        q_s.delete();
        q_r.delete();
        done_cnt++;
      end else begin
        chk("ld_fr", ld_fr, int'(cyc == 1));
        chk("ld_fw", ld_fw, int'(cyc == exp_len));
        chk("busy", busy, int'(cyc <= exp_len));
        chk("ready", ready, int'(cyc > exp_len));
        chk("err", err, 0);
        if (ld_fw) fw_cyc = cyc;
        if (start_stage != 0 && prev_ss == 0) begin
          chk("launch_pending", int'(q_s.size() > 0), 1);
          if (q_s.size() > 0) begin
            cur_s = q_s.pop_front();
            cur_r = q_r.pop_front();
            n_launch++;
          end
        end
        if (start_stage != 0) begin
          hold++;
          chk("start_onehot", start_stage, 1 << cur_s);
        end
        if (start_stage == 0 && prev_ss != 0) begin
          chk("start_hold", hold, ack_after[cur_s]);
          if (cur_s == 2) hold2 = hold;
          hold = 0;
        end
        if (cyc >= 2 && cyc < exp_len) begin
          chk("stage_idx", stage_idx, cur_s);
          chk("round_idx", round_idx, cur_r);
        end
        if (cyc == exp_len + 1) begin
          chk("end_stage_idx", stage_idx, 0);
          chk("end_round_idx", round_idx, 0);
          chk("launches_left", q_s.size(), 0);
          chk("fw_cycle", fw_cyc, lit_fw);
          chk("launch_count", n_launch, lit_launch);
          if (lit_hold2 > 0) chk("stage2_hold", hold2, lit_hold2);
          m_act = 1'b0;
          done_cnt++;
        end
      end
      prev_ss = start_stage;
    end else if (err_ph) begin
      chk("errph_flag", err, 1);
      chk("errph_ready", ready, 0);
      chk("errph_busy", busy, 0);
      chk("errph_start_stage", start_stage, 0);
      if (start) err_ph = 1'b0;
    end else begin
      chk("idle_ready", ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_start_stage", start_stage, 0);
      chk("idle_ld", {30'd0, ld_fr, ld_fw}, 0);
      chk("idle_err", err, 0);
      if (start) begin
        cyc = 0; exp_len = 2; fw_cyc = -1; n_launch = 0;
        hold = 0; hold2 = 0; cur_s = 0; cur_r = 0;
        for (int r = 0; r < int'(num_rounds); r++)
          for (int s = 0; s < NS; s++)
            if (stage_mask[s]) begin
              q_s.push_back(s);
              q_r.push_back(r);
              exp_len += ack_after[s] + 1 + low_len[s];
            end
        m_act = 1'b1;
      end
      prev_ss = start_stage;
    end
  end

  task automatic go(input int nr, input logic [NS-1:0] m, input int lfw,
                    input int lln, input int lh2, input bit pert);
    int d0;
    int guard;
    d0 = done_cnt;
    guard = 0;
    lit_fw = lfw; lit_launch = lln; lit_hold2 = lh2;
    @(posedge clk); #1;
    start = 1'b1; num_rounds = RW'(nr); stage_mask = m;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == d0 && guard < 4000) begin
      if (pert && busy && !ld_fw) begin
        start      = 1'($urandom_range(0, 1));
        stage_mask = NS'($urandom);
        num_rounds = RW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      ack_after[i] = 1;
      low_len[i]   = 2;
    end
    lit_err_cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    go(1,  5'b11111, 22,  5,  0, 1'b0);
    go(3,  5'b10101, 38,  9,  0, 1'b0);
    go(0,  5'b11111, 2,   0,  0, 1'b0);
    go(2,  5'b00000, 2,   0,  0, 1'b0);
    ack_after[2] = 4;
    go(1,  5'b11111, 25,  5,  4, 1'b0);
    ack_after[2] = 1;
    go(2,  5'b01011, 26,  6,  0, 1'b1);
    go(31, 5'b10000, 126, 31, 0, 1'b0);

    // Abort in WAIT of round 1.
    @(posedge clk); #1;
    start = 1'b1; num_rounds = 5'd3; stage_mask = 5'b11111;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int   g;
      logic pv;
      g = 0;
      pv = 1'b1;
      while (!(round_idx == 5'd1 && busy && start_stage == '0 &&
               !ready_stage[stage_idx] && !pv) && g < 500) begin
        pv = |start_stage;
        @(posedge clk); #1;
        g++;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);

`ifdef STAGE_TIMEOUT_EN
    low_len[3]  = 100000;
    lit_err_cyc = 30;
    go(1, 5'b11111, 0, 0, 0, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
